// File: rtl/seg_pkg.sv
// seg_pkg: shared constants and helpers for the seven-segment scan controller.
//   - Digit code constants (dash, blank).
//   - Active-low segment patterns, bit order {g,f,e,d,c,b,a}.
//   - anode_low(): one-hot-low anode pattern for a digit index.
package seg_pkg;

  localparam int MAX_DIGITS = 8;

  localparam logic [3:0] CODE_DASH  = 4'd10;
  localparam logic [3:0] CODE_BLANK = 4'd11;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_ALL   = 7'b0000000;

  // All ones except a single zero at position idx (active-low anode select).
  function automatic logic [MAX_DIGITS-1:0] anode_low(input logic [2:0] idx);
    anode_low = ~(8'b0000_0001 << idx);
  endfunction

endpackage

// File: rtl/seg_decode.sv
// seg_decode: combinational 4-bit digit code to active-low 7-segment pattern.
//   code  in  4  0-9 digits, 10 dash, 11 blank, 12-15 all segments lit
//   seg   out 7  {g,f,e,d,c,b,a}, active-low
module seg_decode
  import seg_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_ALL;
    case (code)
      4'd0:       seg = SEG_0;
      4'd1:       seg = SEG_1;
      4'd2:       seg = SEG_2;
      4'd3:       seg = SEG_3;
      4'd4:       seg = SEG_4;
      4'd5:       seg = SEG_5;
      4'd6:       seg = SEG_6;
      4'd7:       seg = SEG_7;
      4'd8:       seg = SEG_8;
      4'd9:       seg = SEG_9;
      CODE_DASH:  seg = SEG_DASH;
      CODE_BLANK: seg = SEG_BLANK;
      default:    seg = SEG_ALL;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: multiplexed N-digit common-anode seven-segment controller.
//   clk         in   1              system clock
//   rst         in   1              asynchronous reset, active-low
//   digits      in   4*NUM_DIGITS   digit codes, digit 0 rightmost
//   dp_in       in   NUM_DIGITS     decimal point request, 1 = lit
//   blink_mask  in   NUM_DIGITS     1 = digit blinks
//   lz_suppress in   1              1 = blank leading zeros
//   enable      in   1              0 = dark, counters and shadow hold
//   an          out  NUM_DIGITS     anode enables, active-low
//   seg         out  7              segments {g,f,e,d,c,b,a}, active-low
//   dp          out  1              decimal point, active-low
//   frame_tick  out  1              one-cycle pulse after each frame end
// Inputs are captured into a shadow register only at frame end so a frame
// never mixes old and new values. All outputs are registered (1-cycle latency).
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 100000,
  parameter int BLANK_CYCLES = 2000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic                    lz_suppress,
  input  logic                    enable,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic                    frame_tick
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);
  localparam logic [BW-1:0] BLK_LAST  = BW'(BLINK_FRAMES - 1);

  logic [CW-1:0]           cnt;
  logic [IW-1:0]           idx;
  logic [BW-1:0]           blink_cnt;
  logic                    blink_phase;
  logic [4*NUM_DIGITS-1:0] shadow_dig;
  logic [NUM_DIGITS-1:0]   shadow_dp;

  logic                    slot_end;
  logic                    frame_end;
  logic [NUM_DIGITS-1:0]   lz_blank;
  logic                    above_clear;
  logic [3:0]              lz_code;
  logic [3:0]              cur_code;
  logic [3:0]              dec_code;
  logic [6:0]              dec_seg;
  logic                    blink_off;
  logic [2:0]              idx_ext;
  logic [MAX_DIGITS-1:0]   an_full;

  assign slot_end  = (cnt == CNT_LAST);
  assign frame_end = enable && slot_end && (idx == IDX_LAST);

  // Walk from the most significant digit down: a digit is a leading zero
  // while every digit above it is zero or blank. Digit 0 is never touched.
  always_comb begin
    above_clear = 1'b1;
    lz_code     = 4'd0;
    lz_blank    = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      lz_code     = shadow_dig[4*i +: 4];
      lz_blank[i] = lz_suppress && above_clear && (lz_code == 4'd0);
      above_clear = above_clear && ((lz_code == 4'd0) || (lz_code == CODE_BLANK));
    end
  end

  always_comb begin
    idx_ext          = '0;
    idx_ext[IW-1:0]  = idx;
    an_full          = anode_low(idx_ext);
    cur_code         = shadow_dig[{idx, 2'b00} +: 4];
    dec_code         = lz_blank[idx] ? CODE_BLANK : cur_code;
    blink_off        = blink_phase && blink_mask[idx];
  end

  seg_decode u_decode (
    .code (dec_code),
    .seg  (dec_seg)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt         <= '0;
      idx         <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      shadow_dig  <= {NUM_DIGITS{CODE_BLANK}};
      shadow_dp   <= '0;
      an          <= '1;
      seg         <= SEG_BLANK;
      dp          <= 1'b1;
      frame_tick  <= 1'b0;
    end else begin
      frame_tick <= frame_end;
      if (enable) begin
        // Anode stays off for the first BLANK_CYCLES of each slot so the
        // previous digit's segments never ghost onto the new digit.
        an  <= (cnt >= CNT_BLANK) ? an_full[NUM_DIGITS-1:0] : '1;
        seg <= blink_off ? SEG_BLANK : dec_seg;
        dp  <= blink_off ? 1'b1 : ~shadow_dp[idx];

        if (slot_end) begin
          cnt <= '0;
          idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
        end else begin
          cnt <= cnt + CW'(1);
        end

        if (frame_end) begin
          shadow_dig <= digits;
          shadow_dp  <= dp_in;
          if (blink_cnt == BLK_LAST) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
          end else begin
            blink_cnt <= blink_cnt + BW'(1);
          end
        end
      end else begin
        an  <= '1;
        seg <= SEG_BLANK;
        dp  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: self-checking bench for seg_scan_ctrl (N=4, SCAN_DIV=8,
// BLANK_CYCLES=2, BLINK_FRAMES=2). The reference model counts enabled cycles
// since reset and derives slot, digit, frame and blink phase arithmetically.
module tb_seg_scan_ctrl;

  localparam int N     = 4;
  localparam int DIV   = 8;
  localparam int BLANK = 2;
  localparam int BLINK = 2;
  localparam int FRAME = N * DIV;

  logic           clk = 1'b0;
  logic           rst;
  logic [4*N-1:0] digits;
  logic [N-1:0]   dp_in;
  logic [N-1:0]   blink_mask;
  logic           lz_suppress;
  logic           enable;
  logic [N-1:0]   an;
  logic [6:0]     seg;
  logic           dp;
  logic           frame_tick;

  int total = 0;
  int bad   = 0;

  // clock / reset
  always #5 clk = ~clk;

  seg_scan_ctrl #(
    .NUM_DIGITS   (N),
    .SCAN_DIV     (DIV),
    .BLANK_CYCLES (BLANK),
    .BLINK_FRAMES (BLINK)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .digits      (digits),
    .dp_in       (dp_in),
    .blink_mask  (blink_mask),
    .lz_suppress (lz_suppress),
    .enable      (enable),
    .an          (an),
    .seg         (seg),
    .dp          (dp),
    .frame_tick  (frame_tick)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] ref_seg(input logic [3:0] code);
    case (code)
      4'd0:  return 7'h40;
      4'd1:  return 7'h79;
      4'd2:  return 7'h24;
      4'd3:  return 7'h30;
      4'd4:  return 7'h19;
      4'd5:  return 7'h12;
      4'd6:  return 7'h02;
      4'd7:  return 7'h78;
      4'd8:  return 7'h00;
      4'd9:  return 7'h10;
      4'd10: return 7'h3F;
      4'd11: return 7'h7F;
      default: return 7'h00;
    endcase
  endfunction

  // reference model state
  int         m_k;        // enabled cycles since reset
  int         m_frames;   // completed frames since reset
  logic [3:0] m_dig [N];
  logic       m_dp  [N];

  logic [N-1:0] exp_an;
  logic [6:0]   exp_seg;
  logic         exp_dp;
  logic         exp_tick;

  int         r_cnt, r_idx, r_phase;
  logic       r_fe, r_sup, r_boff;
  logic [3:0] r_code;

  always @(posedge clk) begin
    if (!rst) begin
      m_k = 0;
      m_frames = 0;
      for (int i = 0; i < N; i++) begin
        m_dig[i] = 4'hB;
        m_dp[i]  = 1'b0;
      end
      exp_an = '1; exp_seg = 7'h7F; exp_dp = 1'b1; exp_tick = 1'b0;
    end else begin
      r_cnt   = m_k % DIV;
      r_idx   = (m_k / DIV) % N;
      r_phase = (m_frames / BLINK) % 2;
      r_fe    = enable && ((m_k % FRAME) == FRAME - 1);
      exp_tick = r_fe;
      if (enable) begin
        r_code = m_dig[r_idx];
        r_sup  = lz_suppress && (r_idx != 0) && (r_code == 4'd0);
        for (int j = r_idx + 1; j < N; j++)
          if (!(m_dig[j] == 4'd0 || m_dig[j] == 4'hB)) r_sup = 1'b0;
        r_boff  = (r_phase == 1) && blink_mask[r_idx];
        exp_an  = '1;
        if (r_cnt >= BLANK) exp_an[r_idx] = 1'b0;
        exp_seg = (r_boff || r_sup) ? 7'h7F : ref_seg(r_code);
        exp_dp  = r_boff ? 1'b1 : !m_dp[r_idx];
        if (r_fe) begin
          for (int i = 0; i < N; i++) begin
            m_dig[i] = digits[4*i +: 4];
            m_dp[i]  = dp_in[i];
          end
          m_frames++;
        end
        m_k++;
      end else begin
        exp_an = '1; exp_seg = 7'h7F; exp_dp = 1'b1;
      end
    end
    #1;
    check("an", 32'(an), 32'(exp_an));
    check("seg", 32'(seg), 32'(exp_seg));
    check("dp", 32'(dp), 32'(exp_dp));
    check("frame_tick", 32'(frame_tick), 32'(exp_tick));
    check("an_onehot", 32'($countones(~an) <= 1), 32'd1);
  end

  // driver tasks
  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    digits = 16'h1234; dp_in = '0; blink_mask = '0; lz_suppress = 1'b0; enable = 1'b1;
    #1 rst = 1'b0;
    run(3);
    rst = 1'b1;

    // first frame blank, then 1234, scan order and blanking
    run(FRAME * 3 + 11);
    // mid-frame capture change
    digits = 16'h5678;
    run(FRAME * 2 + 5);

    // leading zero suppression
    digits = 16'h0070; lz_suppress = 1'b1;
    run(FRAME * 3);
    digits = 16'h0000;
    run(FRAME * 3);
    digits = 16'h0B05;
    run(FRAME * 3);

    // blink and decimal point
    lz_suppress = 1'b0; digits = 16'h1234; blink_mask = 4'b0001; dp_in = 4'b0010;
    run(FRAME * 6);

    // disable at cnt=5, idx=2 (model state seen by the next edge)
    for (int w = 0; w < FRAME * 2; w++) begin
      if ((m_k % DIV) == 5 && ((m_k / DIV) % N) == 2) break;
      run(1);
    end
    check("disable_point", 32'(m_k % FRAME), 32'(2 * DIV + 5));
    enable = 1'b0;
    run(7);
    enable = 1'b1;
    run(FRAME + 3);

    // asynchronous reset pulse mid-slot
    run(3);
    rst = 1'b0;
    #1;
    check("async_an", 32'(an), 32'hF);
    check("async_seg", 32'(seg), 32'h7F);
    check("async_dp", 32'(dp), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    run(FRAME * 2 + 4);

    // randomized stimulus
    for (int c = 0; c < 1200; c++) begin
      if ($urandom_range(0, 19) == 0) digits = 16'($urandom);
      if ($urandom_range(0, 19) == 0) dp_in = 4'($urandom);
      if ($urandom_range(0, 29) == 0) blink_mask = 4'($urandom);
      if ($urandom_range(0, 29) == 0) lz_suppress = 1'($urandom);
      if ($urandom_range(0, 15) == 0) enable = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 4) == 0) begin
        // bias toward codes with zeros/blanks to exercise suppression
        digits[4*$urandom_range(0, 3) +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'hB;
      end
      run(1);
    end
    enable = 1'b1;
    run(FRAME);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Parametrised multiplexed seven-segment display controller for an N-digit common-anode display. It replaces the free-running one-hot anode rotator and the separate decoder with one block. The block provides:
- prescaled scan rate
- anti-ghosting blanking interval
- frame-synchronous input capture
- per-digit decimal point and blink
- leading-zero suppression
- registered, glitch-free anode, segment and decimal-point outputs

It sits between game/score logic and the board's an/seg/dp pins.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (2..8)
SCAN_DIV, 100000, clk cycles per digit slot (>= 4)
BLANK_CYCLES, 2000, cycles at start of each slot with all anodes off (1 <= BLANK_CYCLES < SCAN_DIV)
BLINK_FRAMES, 64, full frames per blink half-period (>= 1)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-low
digits  in  4*NUM_DIGITS  digit codes; digit i at [4i+3:4i], digit 0 rightmost
dp_in  in  NUM_DIGITS  per-digit decimal point request, 1 = lit
blink_mask  in  NUM_DIGITS  1 = digit blinks
lz_suppress  in  1  1 = blank leading zeros
enable  in  1  0 = display dark, counters hold
an  out  NUM_DIGITS  anode enables, active-low, one-hot-zero or all ones
seg  out  7  segments {g,f,e,d,c,b,a}, active-low
dp  out  1  decimal point, active-low
frame_tick  out  1  one-cycle pulse at end of each full frame

Behaviour:
- Reset (rst=0, async) values:
  - an = all ones, seg = 7'b1111111, dp = 1, frame_tick = 0
  - slot counter cnt = 0, digit index idx = 0, blink counter = 0, blink_phase = 0
  - shadow digit register = all 4'hB (blank), shadow dp = 0
- Counters, when enable=1:
  - cnt counts 0..SCAN_DIV-1.
  - At cnt = SCAN_DIV-1, cnt returns to 0 and idx advances. idx wraps from NUM_DIGITS-1 to 0.
  - idx is $clog2(NUM_DIGITS) bits wide. Non-power-of-two NUM_DIGITS must wrap at NUM_DIGITS-1.
- Frame end is the cycle with cnt = SCAN_DIV-1 and idx = NUM_DIGITS-1. At frame end:
  - shadow digits and shadow dp load from digits/dp_in
  - frame_tick = 1 on the next cycle (registered)
  - blink counter advances 0..BLINK_FRAMES-1; on wrap, blink_phase toggles
- Inputs are sampled only at frame end. Mid-frame input changes have no visible effect.
- Output pipeline: an/seg/dp at cycle t+1 are a function of (idx, cnt, shadow, blink_phase, lz_suppress, enable) at cycle t. Latency is 1 cycle.
- Anode:
  - an[idx] = 0 only when cnt >= BLANK_CYCLES; otherwise all ones.
  - Never more than one anode low.
- Decode:
  - codes 0-9 map to the digits
  - 10 maps to dash 7'b0111111
  - 11 maps to blank 7'b1111111
  - 12-15 map to all lit 7'b0000000
- Leading-zero suppression (lz_suppress=1):
  - Digit i is blanked if its shadow code is 0 and every digit j > i is 0 or blanked.
  - Digit 0 is never suppressed.
  - A suppressed digit's dp still follows shadow dp.
- Blink: when blink_phase=1 and blink_mask[idx]=1, seg = blank and dp = 1. The anode timing is unchanged.
- Disable (enable=0):
  - Next cycle: an = all ones, seg = blank, dp = 1.
  - All counters and the shadow hold.
  - On re-enable, scan resumes from the held cnt/idx.
- Reset asserted mid-frame: all state returns to reset values immediately. The first frame after reset release displays blank.

Decomposition:
- Package seg_pkg holds:
  - code constants CODE_DASH=4'd10, CODE_BLANK=4'd11
  - segment constants SEG_0..SEG_9, SEG_DASH, SEG_BLANK, SEG_ALL
  - helper function for the one-hot-low anode pattern
- One combinational sub-module, seg_decode (4-bit code to 7-bit active-low segments), using seg_pkg.
- Counters, shadow, blanking, suppression and output registers live in seg_scan_ctrl.

Test Plan:
(Parameters NUM_DIGITS=4, SCAN_DIV=8, BLANK_CYCLES=2, BLINK_FRAMES=2.)
1. Reset/first frame: release rst, digits=16'h1234.
   -> First 32 cycles: seg = 7'b1111111 on every slot.
   -> From cycle 33: slot 0 seg = 7'b0011001 ('4') with an = 4'b1110 during cnt 2..7 (delayed 1 cycle); all ones during cnt 0..1.
   -> frame_tick pulses once per 32 cycles.
2. Scan order and exclusivity:
   -> an sequence 1110, 1101, 1011, 0111, repeating.
   -> Checker asserts popcount(~an) <= 1 every cycle.
   -> an = 4'b1111 for 2 cycles at each slot start.
3. Frame-synchronous capture: change digits from 16'h1234 to 16'h5678 mid-frame.
   -> Display holds 1234 until the next frame end, then shows 5678. No mixed frame appears.
4. Leading zeros: digits=16'h0070, lz_suppress=1.
   -> Digits 3 and 2 blank; digit 1 shows '7'; digit 0 shows '0'.
   -> digits=16'h0000 shows only digit 0 as '0'.
5. Blink and dp: blink_mask=4'b0001, dp_in=4'b0010.
   -> Digit 0 seg alternates: lit for 2 frames, blank for 2 frames.
   -> Digit 1 dp = 0 in every frame.
   -> Other digits are steady.
6. enable/reset mid-operation:
   -> enable=0 at cnt=5, idx=2: outputs dark next cycle; cnt and idx hold; resume at the same slot after enable=1.
   -> rst pulse low for 1 cycle mid-slot: an = 4'b1111 asynchronously; idx=0 afterwards.
